// File: rtl/riscy_btb.sv
// riscy_btb: 2-way set-associative branch target buffer for the fetch stage.
//
// Supplies the target PC of a predicted-taken branch/jal in IF so fetch can
// redirect early. Entries are allocated or refreshed from resolved taken
// branches and jals in EX. One LRU bit per set names the victim way.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   if_valid, if_PC         fetch lookup request
//   if_hit, if_target       combinational lookup result (target is 0 on miss)
//   ex_valid, ex_PC, ex_IR  resolved instruction in EX
//   ex_taken, ex_target     branch outcome and resolved target
//   clear                   synchronous invalidate-all
//   lookup_cnt, hit_cnt     saturating performance counters
module riscy_btb #(
  parameter int unsigned SETS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_PC,
  output logic        if_hit,
  output logic [31:0] if_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_PC,
  input  logic [31:0] ex_IR,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        clear,
  output logic [31:0] lookup_cnt,
  output logic [31:0] hit_cnt
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDX;

  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // Per-way valid bits and per-set victim pointer.
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0]      lru_q, lru_d;

  // Tag and target storage, indexed [way][set].
  logic [TAGW-1:0] tag_q [2][SETS];
  logic [31:0]     tgt_q [2][SETS];

  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;

  logic [IDX-1:0]  if_idx, ex_idx;
  logic [TAGW-1:0] if_tag, ex_tag;
  logic [1:0]      if_match, ex_match;
  logic            upd;
  logic            wsel;

  assign if_idx = if_PC[IDX+1:2];
  assign if_tag = if_PC[31:IDX+2];
  assign ex_idx = ex_PC[IDX+1:2];
  assign ex_tag = ex_PC[31:IDX+2];

  // Instruction-alignment bits and non-opcode fields carry no information here.
  logic unused_bits;
  assign unused_bits = ^{if_PC[1:0], ex_PC[1:0], ex_IR[31:7]};

  // Lookup reads registered state only, so a same-cycle update is not visible.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    if_match    = '0;
    if_target   = '0;
    if_match[0] = valid_q[0][if_idx] && (tag_q[0][if_idx] == if_tag);
    if_match[1] = valid_q[1][if_idx] && (tag_q[1][if_idx] == if_tag);
    if_hit      = |if_match;
    if (if_match[0])      if_target = tgt_q[0][if_idx];
    else if (if_match[1]) if_target = tgt_q[1][if_idx];
  end

  // Update qualification and way selection: refresh a matching way first,
  // then fill the lowest invalid way, and only then evict the LRU victim.
  always_comb begin
    ex_match    = '0;
    ex_match[0] = valid_q[0][ex_idx] && (tag_q[0][ex_idx] == ex_tag);
    ex_match[1] = valid_q[1][ex_idx] && (tag_q[1][ex_idx] == ex_tag);
    upd = ex_valid && !clear &&
          ((ex_IR[6:0] == OP_JAL) || ((ex_IR[6:0] == OP_BR) && ex_taken));
    if (ex_match[0])              wsel = 1'b0;
    else if (ex_match[1])         wsel = 1'b1;
    else if (!valid_q[0][ex_idx]) wsel = 1'b0;
    else if (!valid_q[1][ex_idx]) wsel = 1'b1;
    else                          wsel = lru_q[ex_idx];
  end

  always_comb begin
    valid_d = valid_q;
    lru_d   = lru_q;
    if (clear) begin
      valid_d = '0;
      lru_d   = '0;
    end else if (upd) begin
      valid_d[wsel][ex_idx] = 1'b1;
      lru_d[ex_idx]         = ~wsel;
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_comb begin
    lookup_cnt_d = lookup_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    if (if_valid && (lookup_cnt_q != '1))
      lookup_cnt_d = lookup_cnt_q + 32'd1;
    if (if_valid && if_hit && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      lru_q        <= '0;
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      lru_q        <= lru_d;
      lookup_cnt_q <= lookup_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  // NOTE: tag/target arrays are deliberately left out of reset; the valid
  // bits gate every use, so resetting the storage would only cost hardware.
  always_ff @(posedge clk) begin
    if (upd) begin
      tag_q[wsel][ex_idx] <= ex_tag;
      tgt_q[wsel][ex_idx] <= ex_target;
    end
  end

  assign lookup_cnt = lookup_cnt_q;
  assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_riscy_btb.sv
// tb_riscy_btb: scoreboard bench for riscy_btb.
//
// The driver applies one cycle of stimulus just after each rising edge,
// predicts the lookup result and counter values from a reference model, and
// queues the prediction. A monitor on the falling edge pops a prediction for
// every cycle where a lookup is presented and compares it with the DUT.
//
// The reference model keeps the table as one list of {PC word, target}
// ordered by write time: a set holds at most two entries, a refresh moves an
// entry to the back, and a full set evicts its oldest-written entry.
`timescale 1ns/1ps
module tb_riscy_btb;

  localparam int SETS = 16;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_PC = '0;
  logic        if_hit;
  logic [31:0] if_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_PC = '0;
  logic [31:0] ex_IR = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        clear = 1'b0;
  logic [31:0] lookup_cnt;
  logic [31:0] hit_cnt;

  riscy_btb #(.SETS(SETS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid   (if_valid),
    .if_PC      (if_PC),
    .if_hit     (if_hit),
    .if_target  (if_target),
    .ex_valid   (ex_valid),
    .ex_PC      (ex_PC),
    .ex_IR      (ex_IR),
    .ex_taken   (ex_taken),
    .ex_target  (ex_target),
    .clear      (clear),
    .lookup_cnt (lookup_cnt),
    .hit_cnt    (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] key;   // PC[31:2]: set index plus tag
    logic [31:0] tgt;
  } ment_t;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
    logic [31:0] lcnt;
    logic [31:0] hcnt;
  } exp_t;

  ment_t       mtab[$];
  exp_t        sb[$];
  logic [31:0] m_lcnt = '0;
  logic [31:0] m_hcnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int set_of(input logic [29:0] key);
    return int'(key % SETS);
  endfunction

  task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic [31:0] tgt);
    hit = 1'b0;
    tgt = '0;
    foreach (mtab[i]) begin
      if (mtab[i].key == pc[31:2]) begin
        hit = 1'b1;
        tgt = mtab[i].tgt;
      end
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt);
    logic [29:0] key;
    int n;
    int first;
    ment_t e;
    key = pc[31:2];
    e.key = key;
    e.tgt = tgt;
    for (int i = 0; i < mtab.size(); i++) begin
      if (mtab[i].key == key) begin
        mtab.delete(i);
        mtab.push_back(e);
        return;
      end
    end
    n = 0;
    first = -1;
    for (int i = 0; i < mtab.size(); i++) begin
      if (set_of(mtab[i].key) == set_of(key)) begin
        n++;
        if (first < 0) first = i;
      end
    end
    if (n >= 2) mtab.delete(first);
    mtab.push_back(e);
  endtask

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic cycle(input logic iv, input logic [31:0] ipc,
                       input logic ev, input logic [31:0] epc, input logic [6:0] op,
                       input logic tk, input logic [31:0] etgt, input logic clr);
    logic        h;
    logic [31:0] t;
    exp_t        x;
    if_valid  = iv;
    if_PC     = ipc;
    ex_valid  = ev;
    ex_PC     = epc;
    ex_IR     = $urandom();
    ex_IR[6:0] = op;
    ex_taken  = tk;
    ex_target = etgt;
    clear     = clr;
    if (!rst_n) begin
      mtab.delete();
      m_lcnt = '0;
      m_hcnt = '0;
      h = 1'b0;
      t = '0;
    end else begin
      model_lookup(ipc, h, t);
    end
    if (iv) begin
      x.pc = ipc; x.hit = h; x.tgt = t; x.lcnt = m_lcnt; x.hcnt = m_hcnt;
      sb.push_back(x);
    end
    if (rst_n) begin
      if (iv && (m_lcnt != 32'hFFFF_FFFF)) m_lcnt = m_lcnt + 1;
      if (iv && h && (m_hcnt != 32'hFFFF_FFFF)) m_hcnt = m_hcnt + 1;
      if (clr) mtab.delete();
      else if (ev && ((op == OP_JAL) || ((op == OP_BR) && tk))) model_update(epc, etgt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(1'b1, pc, 1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [6:0] op, input logic tk,
                     input logic [31:0] tgt);
    cycle(1'b0, 32'h0, 1'b1, pc, op, tk, tgt, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
    return p;
  endfunction

  // Monitor: one prediction per presented lookup.
  always @(negedge clk) begin
    exp_t e;
    if (if_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_lookup: got lookup of %h expected none queued", if_PC);
      end else begin
        e = sb.pop_front();
        check($sformatf("if_hit@%h", e.pc), {31'b0, if_hit}, {31'b0, e.hit});
        check($sformatf("if_target@%h", e.pc), if_target, e.tgt);
        check($sformatf("lookup_cnt@%h", e.pc), lookup_cnt, e.lcnt);
        check($sformatf("hit_cnt@%h", e.pc), hit_cnt, e.hcnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] ops [4];
    ops[0] = OP_JAL; ops[1] = OP_BR; ops[2] = OP_JALR; ops[3] = OP_ALU;

    @(posedge clk);
    #1;
    // Under reset: lookup sees nothing and the update is discarded.
    cycle(1'b1, 32'h40, 1'b1, 32'h40, OP_JAL, 1'b0, 32'h200, 1'b0);
    rst_n = 1'b1;
    look(32'h40);

    // Allocate then hit, including the same-cycle lookup that must miss.
    cycle(1'b1, 32'h40, 1'b1, 32'h40, OP_JAL, 1'b0, 32'h200, 1'b0);
    look(32'h40);

    // LRU eviction within set 0.
    upd(32'h40,  OP_BR, 1'b1, 32'h1000);
    upd(32'h440, OP_BR, 1'b1, 32'h2000);
    upd(32'h840, OP_BR, 1'b1, 32'h3000);
    look(32'h40);
    look(32'h440);
    look(32'h840);

    // Non-allocating instructions and in-place target refresh.
    upd(32'h84, OP_BR,   1'b0, 32'h500);
    upd(32'h94, OP_JALR, 1'b1, 32'h500);
    look(32'h84);
    look(32'h94);
    upd(32'h88, OP_BR, 1'b1, 32'h500);
    upd(32'h88, OP_BR, 1'b1, 32'h600);
    upd(32'h488, OP_BR, 1'b1, 32'h700);
    look(32'h88);
    look(32'h488);

    // Clear together with an update: clear wins.
    cycle(1'b1, 32'h440, 1'b1, 32'hC0, OP_JAL, 1'b0, 32'h700, 1'b1);
    look(32'hC0);
    look(32'h440);
    look(32'h88);

    // Asynchronous reset mid-run with a populated entry under lookup.
    upd(32'h100, OP_JAL, 1'b0, 32'h900);
    look(32'h100);
    rst_n = 1'b0;
    look(32'h100);
    rst_n = 1'b1;
    look(32'h100);

    // Counter saturation from a preloaded near-full value.
    upd(32'h40, OP_JAL, 1'b0, 32'h200);
    force dut.lookup_cnt_q = 32'hFFFF_FFFE;
    force dut.hit_cnt_q    = 32'hFFFF_FFFE;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0);
    release dut.lookup_cnt_q;
    release dut.hit_cnt_q;
    m_lcnt = 32'hFFFF_FFFE;
    m_hcnt = 32'hFFFF_FFFE;
    repeat (4) look(32'h40);

    // Randomized traffic concentrated on a few sets to exercise eviction.
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 3) != 0), rand_pc(),
            ($urandom_range(0, 3) != 0), rand_pc(), ops[$urandom_range(0, 3)],
            1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 59) == 0));
    end

    cycle(1'b0, 32'h0, 1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0);
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
